// File: rtl/ov7670_config.sv
// OV7670 register configuration sequencer.
// Walks a register-table ROM and issues one SCCB write per entry, waiting
// for each write to finish. The entry 16'hFFFF ends the sequence and the
// entry 16'hFFF0 inserts a fixed delay of DELAY_MS milliseconds.
// Optional feature macro: OV7670_CFG_RETRY_EN. When it is defined, a NACKed
// write is re-issued up to four attempts in total before err is set.
// When it is undefined, a NACK sets err at once and the sequencer moves on.
module ov7670_config #(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned DELAY_MS    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        sccb_start,
    output logic [7:0]  sccb_addr,
    output logic [7:0]  sccb_data,
    input  logic        sccb_ready,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // The delay length is fixed when the design is built. A 64-bit product
    // keeps large clock rates from overflowing before the divide by 1000.
    localparam logic [63:0] DELAY_CYCLES_64 = (64'(DELAY_MS) * 64'(CLK_FREQ_HZ)) / 64'd1000;
    localparam logic [31:0] DELAY_CYCLES    = DELAY_CYCLES_64[31:0];
    localparam logic [31:0] DELAY_LAST      = (DELAY_CYCLES == 32'd0) ? 32'd0 : (DELAY_CYCLES - 32'd1);

    localparam logic [15:0] END_MARKER   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        WAIT_ACK,
        DELAY,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [7:0]  sccb_addr_q, sccb_addr_d;
    logic [7:0]  sccb_data_q, sccb_data_d;
    logic        err_q, err_d;
    logic [31:0] delay_cnt_q, delay_cnt_d;
    logic        advance;

`ifdef OV7670_CFG_RETRY_EN
    logic [1:0]  attempt_q, attempt_d;
`endif

    // Next-state logic. Finished entries and finished delays share the
    // "advance" path, which stops at address 255 instead of wrapping.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        sccb_addr_d = sccb_addr_q;
        sccb_data_d = sccb_data_q;
        err_d       = err_q;
        delay_cnt_d = delay_cnt_q;
        sccb_start  = 1'b0;
        advance     = 1'b0;
`ifdef OV7670_CFG_RETRY_EN
        attempt_d   = attempt_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d      = 1'b0;
                    rom_addr_d = 8'd0;
                    state_d    = FETCH;
                end
            end

            FETCH: begin
                state_d = DECODE;
            end

            DECODE: begin
                delay_cnt_d = 32'd0;
`ifdef OV7670_CFG_RETRY_EN
                attempt_d   = 2'd0;
`endif
                if (rom_dout == END_MARKER) begin
                    state_d = DONE;
                end else if (rom_dout == DELAY_MARKER) begin
                    state_d = DELAY;
                end else begin
                    sccb_addr_d = rom_dout[15:8];
                    sccb_data_d = rom_dout[7:0];
                    state_d     = WRITE;
                end
            end

            WRITE: begin
                if (sccb_ready) begin
                    sccb_start = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end

            WAIT_ACK: begin
                if (sccb_done) begin
                    if (sccb_nack) begin
`ifdef OV7670_CFG_RETRY_EN
                        if (attempt_q != 2'd3) begin
                            attempt_d = attempt_q + 2'd1;
                            state_d   = WRITE;
                        end else begin
                            err_d   = 1'b1;
                            advance = 1'b1;
                        end
`else
                        err_d   = 1'b1;
                        advance = 1'b1;
`endif
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            DELAY: begin
                if (delay_cnt_q == DELAY_LAST) begin
                    delay_cnt_d = 32'd0;
                    advance     = 1'b1;
                end else begin
                    delay_cnt_d = delay_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (rom_addr_q == 8'hFF) begin
                state_d = DONE;
            end else begin
                rom_addr_d = rom_addr_q + 8'd1;
                state_d    = FETCH;
            end
        end
    end

    // State and datapath registers. Reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= 8'd0;
            sccb_addr_q <= 8'd0;
            sccb_data_q <= 8'd0;
            err_q       <= 1'b0;
            delay_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            sccb_addr_q <= sccb_addr_d;
            sccb_data_q <= sccb_data_d;
            err_q       <= err_d;
            delay_cnt_q <= delay_cnt_d;
        end
    end

`ifdef OV7670_CFG_RETRY_EN
    // Attempt counter for the current entry; cleared when each entry is decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            attempt_q <= 2'd0;
        end else begin
            attempt_q <= attempt_d;
        end
    end
`endif

    assign rom_addr  = rom_addr_q;
    assign sccb_addr = sccb_addr_q;
    assign sccb_data = sccb_data_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);

endmodule
